// File: rtl/mul_ctrl.sv
// mul_ctrl: multi-cycle sequencer for a combinational 32x32 signed multiplier.
//
// The block accepts a multiply request, registers the operands onto the
// multiplier inputs and holds them for MUL_LATENCY cycles. It then captures
// the 64-bit product into HI/LO and pulses done for one cycle. The multiplier
// can therefore be timed as a multicycle path.
//
// Parameters:
//   MUL_LATENCY  cycles the operands are held before sampling (1..15)
//
// Optional feature macro:
//   MUL_ABORT_EN  adds the abort input, which cancels an in-flight multiply
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request, sampled only while ready=1
//   a_in, b_in       signed operands
//   abort            cancel in-flight multiply (only with MUL_ABORT_EN)
//   ready            IDLE or DONE: a start is accepted this cycle
//   busy             WAIT: operands are being held
//   done             one-cycle completion pulse
//   mul_a, mul_b     registered operands to the multiplier
//   mul_z            product from the multiplier
//   hi_out, lo_out   registered product halves
module mul_ctrl #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
`ifdef MUL_ABORT_EN
    input  logic        abort,
`endif
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    // One-hot encoding keeps the status outputs a plain decode of flops.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        WAIT = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        cancel;

`ifdef MUL_ABORT_EN
    assign cancel = abort;
`else
    assign cancel = 1'b0;
`endif

    // Next-state logic. A request is taken from IDLE or DONE. Accepting it
    // from DONE gives back-to-back operation. A zero operand makes the product
    // known without the multiplier, so WAIT is skipped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mul_a_d = a_in;
                    mul_b_d = b_in;
                    if (a_in == 32'd0 || b_in == 32'd0) begin
                        hi_d    = 32'd0;
                        lo_d    = 32'd0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = 4'(MUL_LATENCY - 1);
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Abort wins over counter expiry. HI/LO keep the old result.
                if (cancel) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    hi_d    = mul_z[63:32];
                    lo_d    = mul_z[31:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mul_a_q <= 32'd0;
            mul_b_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign ready  = state_q[0] | state_q[2];
    assign busy   = state_q[1];
    assign done   = state_q[2];
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: self-checking bench for mul_ctrl.
//
// A behavioural signed multiplier drives mul_z from mul_a/mul_b. The expected
// results come from 64-bit integer arithmetic on the requested operands. The
// expected timing is fixed: MUL_LATENCY+1 cycles to done on the normal path
// and one cycle on the zero path.
module tb_mul_ctrl;

    localparam int L = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
`ifdef MUL_ABORT_EN
    logic        abort;
`endif
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_z;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int total;
    int bad;

    mul_ctrl #(.MUL_LATENCY(L)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
`ifdef MUL_ABORT_EN
        .abort  (abort),
`endif
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_z  (mul_z),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    // Behavioural stand-in for the combinational multiplier.
    assign mul_z = longint'($signed(mul_a)) * longint'($signed(mul_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    // Issues one request from a ready state and follows it to its done pulse.
    // It returns the cycle count, busy cycles, operand-hold violations, the
    // result and a timeout flag.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int busy_cnt, output bit hold_bad,
                           output logic [63:0] prod, output bit to);
        lat = 0; busy_cnt = 0; hold_bad = 0; to = 0; prod = '0;
        start = 1'b1; a_in = a; b_in = b;
        @(posedge clk);
        forever begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) begin
                prod = {hi_out, lo_out};
                break;
            end
            if (busy) begin
                busy_cnt++;
                if (mul_a !== a || mul_b !== b) hold_bad = 1;
            end
            if (lat >= 64) begin
                to = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        start = 1'b0; a_in = '0; b_in = '0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=1", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        total++; if ({mul_a, mul_b} !== 64'd0) begin bad++; $display("[TB] FAIL reset_ops got=%h exp=0", {mul_a, mul_b}); end
        total++; if ({hi_out, lo_out} !== 64'd0) begin bad++; $display("[TB] FAIL reset_hilo got=%h exp=0", {hi_out, lo_out}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bc; bit hb, to; logic [63:0] p;
        run_mul(32'd7, -32'sd3, lat, bc, hb, p, to);
        total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL basic_timeout got=%b exp=0", to); end
        total++; if (lat !== L + 1) begin bad++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", lat, L + 1); end
        total++; if (bc !== L) begin bad++; $display("[TB] FAIL basic_busy got=%0d exp=%0d", bc, L); end
        total++; if (hb !== 1'b0) begin bad++; $display("[TB] FAIL basic_hold got=%b exp=0", hb); end
        total++; if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("[TB] FAIL basic_prod got=%h exp=ffffffffffffffeb", p); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL basic_pulse got=%b exp=0", done); end
        total++; if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("[TB] FAIL basic_hold_hilo got=%h exp=ffffffffffffffeb", {hi_out, lo_out}); end
    endtask

    task automatic test_corners();
        int lat, bc; bit hb, to; logic [63:0] p;
        run_mul(32'h8000_0000, 32'h8000_0000, lat, bc, hb, p, to);
        total++; if (p !== 64'h4000_0000_0000_0000) begin bad++; $display("[TB] FAIL corner_min got=%h exp=4000000000000000", p); end
        @(negedge clk);
        run_mul(32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, bc, hb, p, to);
        total++; if (p !== 64'h3FFF_FFFF_0000_0001) begin bad++; $display("[TB] FAIL corner_max got=%h exp=3fffffff00000001", p); end
        total++; if (lat !== L + 1) begin bad++; $display("[TB] FAIL corner_latency got=%0d exp=%0d", lat, L + 1); end
        @(negedge clk);
    endtask

    task automatic test_zero();
        int lat, bc; bit hb, to; logic [63:0] p;
        run_mul(32'd0, 32'h1234_5678, lat, bc, hb, p, to);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL zero_latency got=%0d exp=1", lat); end
        total++; if (bc !== 0) begin bad++; $display("[TB] FAIL zero_busy got=%0d exp=0", bc); end
        total++; if (p !== 64'd0) begin bad++; $display("[TB] FAIL zero_prod got=%h exp=0", p); end
        @(negedge clk);
        run_mul(32'd9, 32'd4, lat, bc, hb, p, to);
        run_mul(32'hDEAD_BEEF, 32'd0, lat, bc, hb, p, to);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL zero_b_latency got=%0d exp=1", lat); end
        total++; if (p !== 64'd0) begin bad++; $display("[TB] FAIL zero_b_prod got=%h exp=0", p); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, bc, exp_lat; bit hb, to; logic [63:0] p;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) a = '0;
            if ($urandom_range(0, 5) == 0) b = '0;
            exp_lat = (a == 0 || b == 0) ? 1 : L + 1;
            run_mul(a, b, lat, bc, hb, p, to);
            total++; if (p !== ref_prod(a, b)) begin bad++; $display("[TB] FAIL rand_prod a=%h b=%h got=%h exp=%h", a, b, p, ref_prod(a, b)); end
            total++; if (lat !== exp_lat) begin bad++; $display("[TB] FAIL rand_latency got=%0d exp=%0d", lat, exp_lat); end
            total++; if (hb !== 1'b0) begin bad++; $display("[TB] FAIL rand_hold got=%b exp=0", hb); end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n, first, second;
        logic [63:0] p1, p2;
        first = -1; second = -1; p1 = '0; p2 = '0;
        start = 1'b1; a_in = 32'd3; b_in = 32'd5;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy got=%b exp=1", busy); end
                a_in = 32'd6; b_in = 32'hFFFF_FFFF;
            end
            if (busy && first < 0) begin
                total++; if (mul_a !== 32'd3) begin bad++; $display("[TB] FAIL b2b_ignore got=%h exp=3", mul_a); end
            end
            if (first > 0 && n == first + 1) start = 1'b0;
            if (done) begin
                if (first < 0) begin
                    first = n; p1 = {hi_out, lo_out};
                end else begin
                    second = n; p2 = {hi_out, lo_out};
                    break;
                end
            end
        end
        start = 1'b0;
        total++; if (second < 0) begin bad++; $display("[TB] FAIL b2b_timeout got=%0d exp=2pulses", first); end
        total++; if (second - first !== L + 1) begin bad++; $display("[TB] FAIL b2b_spacing got=%0d exp=%0d", second - first, L + 1); end
        total++; if (p1 !== 64'd15) begin bad++; $display("[TB] FAIL b2b_first got=%h exp=f", p1); end
        total++; if (p2 !== 64'hFFFF_FFFF_FFFF_FFFA) begin bad++; $display("[TB] FAIL b2b_second got=%h exp=fffffffffffffffa", p2); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int lat, bc, extra; bit hb, to; logic [63:0] p;
        int seen;
        run_mul(32'd11, 32'd13, lat, bc, hb, p, to);
        @(negedge clk);
        start = 1'b1; a_in = 32'd7; b_in = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        extra = (L >= 2) ? 1 : 0;
        repeat (extra) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({hi_out, lo_out} !== 64'd0) begin bad++; $display("[TB] FAIL rst_mid_hilo got=%h exp=0", {hi_out, lo_out}); end
        total++; if ({mul_a, mul_b} !== 64'd0) begin bad++; $display("[TB] FAIL rst_mid_ops got=%h exp=0", {mul_a, mul_b}); end
        total++; if ({ready, busy, done} !== 3'b100) begin bad++; $display("[TB] FAIL rst_mid_status got=%b exp=100", {ready, busy, done}); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (L + 3) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("[TB] FAIL rst_mid_nodone got=%0d exp=0", seen); end
    endtask

`ifdef MUL_ABORT_EN
    task automatic test_abort();
        int lat, bc, seen; bit hb, to; logic [63:0] p;
        run_mul(32'd2, 32'd2, lat, bc, hb, p, to);
        @(negedge clk);
        start = 1'b1; a_in = 32'd5; b_in = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        // Abort in the final WAIT cycle, where it competes with expiry.
        repeat (L - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if ({ready, busy, done} !== 3'b100) begin bad++; $display("[TB] FAIL abort_status got=%b exp=100", {ready, busy, done}); end
        total++; if ({hi_out, lo_out} !== 64'd4) begin bad++; $display("[TB] FAIL abort_hilo got=%h exp=4", {hi_out, lo_out}); end
        seen = 0;
        repeat (L + 2) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("[TB] FAIL abort_nodone got=%0d exp=0", seen); end
        run_mul(32'd3, 32'd3, lat, bc, hb, p, to);
        total++; if (p !== 64'd9) begin bad++; $display("[TB] FAIL abort_next got=%h exp=9", p); end
        @(negedge clk);
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
`ifdef MUL_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_basic();
        test_corners();
        test_zero();
        test_random();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef MUL_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Multi-cycle sequencer for the CPU's combinational 32x32 signed radix-4 Booth multiplier. It accepts a multiply request from the execute stage and holds the operands stable on the multiplier inputs for a programmable number of cycles. It then captures the 64-bit product into HI/LO result registers and reports completion with a one-cycle pulse. This lets the multiplier sit on a declared multicycle path instead of limiting the core clock.

## Interface
- MUL_LATENCY, default 2: cycles the operands are held before the product is sampled; legal range 1..15.
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when ready=1.
- a_in  in  32  multiplicand, signed two's complement.
- b_in  in  32  multiplier, signed two's complement.
- abort  in  1  cancels an in-flight multiply. The port exists only with MUL_ABORT_EN.
- ready  out  1  high in IDLE and DONE; a start is accepted this cycle.
- busy  out  1  high in WAIT; the CPU stalls on it.
- done  out  1  one-cycle pulse; hi_out/lo_out carry the new product.
- mul_a  out  32  registered operand to the multiplier's a input.
- mul_b  out  32  registered operand to the multiplier's b input.
- mul_z  in  64  product from the multiplier.
- hi_out  out  32  product[63:32], registered.
- lo_out  out  32  product[31:0], registered.

## Operation
- States:
  - IDLE: ready=1.
  - WAIT: busy=1.
  - DONE: done=1, ready=1.
- Reset (asynchronous, rst_n=0): state=IDLE, counter=0. mul_a, mul_b, hi_out, lo_out are 0. done=0, busy=0, ready=1.
- IDLE/DONE with start=1:
  - Register a_in→mul_a and b_in→mul_b.
  - Load counter=MUL_LATENCY-1.
  - Go to WAIT.
- Zero fast path: if a_in==0 or b_in==0 at acceptance, skip WAIT. hi_out/lo_out←0 at the same edge and go to DONE.
- WAIT: the counter decrements each cycle.
  - At counter==0: latch mul_z into {hi_out,lo_out} and go to DONE.
  - mul_a/mul_b stay constant for the whole of WAIT.
- DONE with start=0: go to IDLE. DONE with start=1: accept the new request (back-to-back); done is still high this cycle.
- start while busy=1 is ignored and not queued.
- hi_out/lo_out change only at a completion edge; otherwise they hold. done=1 only in DONE.
- Arithmetic: full signed 64-bit product; no truncation or saturation.
  - 0x80000000 × 0x80000000 = 0x4000000000000000.

## Timing
- Start accepted at edge k (normal path): mul_a/mul_b valid after k. Product latched at edge k+MUL_LATENCY. done high during the following cycle.
- Zero fast path: result latched at edge k; done high in the cycle after k.
- MUL_LATENCY=1: WAIT lasts exactly one cycle.
- Throughput:
  - Back-to-back: one product every MUL_LATENCY+1 cycles.
  - Zero operands: one product per cycle.
- rst_n asserted mid-WAIT: state returns to IDLE immediately and hi_out/lo_out clear. No done pulse for the aborted operation.
- All outputs come directly from registers; there is no combinational path from any input to any output.

## Configuration
- MUL_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in WAIT returns the block to IDLE at the next edge. hi_out/lo_out keep their old values and no done pulse is produced.
  - abort has priority over counter expiry in the same cycle.
  - abort in IDLE/DONE has no effect. If abort and start are both high in DONE, start wins.
- MUL_ABORT_EN undefined: no abort port; WAIT always runs to completion.

## Test plan
- Reset, then MUL_LATENCY=2, a=7, b=-3: done high 3 cycles after the start edge. hi=0xFFFFFFFF, lo=0xFFFFFFEB. busy high for exactly 2 cycles.
- a=0x80000000, b=0x80000000 → {hi,lo}=0x4000000000000000. Then a=0x7FFFFFFF, b=0x7FFFFFFF → 0x3FFFFFFF00000001.
- a=0, b=0x12345678: done high in the cycle after the start edge, {hi,lo}=0, busy never asserts.
- Back-to-back: start held high with 3×5 then 6×-1 → two done pulses spaced MUL_LATENCY+1 cycles apart, results 15 and 0xFFFFFFFFFFFFFFFA. A start pulsed during WAIT is ignored.
- rst_n low in the second WAIT cycle → all outputs 0 immediately; no done pulse follows.
- MUL_ABORT_EN: abort in WAIT after a prior 2×2 result → back to IDLE, hi/lo stay 0/4, no done pulse. A new start is accepted the next cycle.
